// File: rtl/rename_pkg.sv
// -----------------------------------------------------------------------------
// rename_pkg
// Shared sizing, tag types and helpers for the rename stage.
//   NUM_AREG / NUM_PREG : architectural / physical register counts
//   AREG_WIDTH / PREG_WIDTH : index widths
//   FL_DEPTH            : free-list entries (need not be a power of two)
//   rename_out_t        : registered rename result handed to dispatch
// -----------------------------------------------------------------------------
package rename_pkg;

    localparam int NUM_AREG   = 32;
    localparam int NUM_PREG   = 64;
    localparam int AREG_WIDTH = $clog2(NUM_AREG);
    localparam int PREG_WIDTH = $clog2(NUM_PREG);
    localparam int FL_DEPTH   = NUM_PREG - NUM_AREG;
    localparam int FL_IDX_W   = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
    localparam int FL_CNT_W   = $clog2(FL_DEPTH + 1);

    typedef logic [AREG_WIDTH-1:0] areg_t;
    typedef logic [PREG_WIDTH-1:0] preg_t;
    typedef logic [FL_IDX_W-1:0]   fl_idx_t;
    typedef logic [FL_CNT_W-1:0]   fl_cnt_t;

    typedef struct packed {
        logic  valid;
        preg_t prd;
        preg_t old_prd;
        preg_t prs1;
        preg_t prs2;
        logic  rs1_ready;
        logic  rs2_ready;
    } rename_out_t;

    // Ring pointer increment; explicit wrap so FL_DEPTH need not be 2^n.
    function automatic fl_idx_t fl_inc(input fl_idx_t p);
        return (p == fl_idx_t'(FL_DEPTH - 1)) ? '0 : p + fl_idx_t'(1);
    endfunction

endpackage

// File: rtl/rename_map_if.sv
// -----------------------------------------------------------------------------
// rename_map_if
// Bundles the decode, dispatch, writeback, commit and flush signals of the
// rename stage.
//   master : decode / FU / ROB side (drives requests, observes results)
//   slave  : rename_map
// -----------------------------------------------------------------------------
interface rename_map_if;
    import rename_pkg::*;

    // decode -> rename
    logic    ren_valid;
    logic    ren_ready;
    logic    ren_reg_write;
    areg_t   ren_rd;
    areg_t   ren_rs1;
    areg_t   ren_rs2;
    // rename -> dispatch
    logic    out_valid;
    preg_t   out_prd;
    preg_t   out_old_prd;
    preg_t   out_prs1;
    preg_t   out_prs2;
    logic    out_rs1_ready;
    logic    out_rs2_ready;
    // FU writeback
    logic    wb_valid;
    preg_t   wb_prd;
    // ROB commit / recovery
    logic    commit_valid;
    logic    commit_reg_write;
    areg_t   commit_rd;
    preg_t   commit_prd;
    preg_t   commit_old_prd;
    logic    flush;
    fl_cnt_t free_count;

    modport master (
        output ren_valid, ren_reg_write, ren_rd, ren_rs1, ren_rs2,
        output wb_valid, wb_prd,
        output commit_valid, commit_reg_write, commit_rd, commit_prd, commit_old_prd,
        output flush,
        input  ren_ready, out_valid, out_prd, out_old_prd, out_prs1, out_prs2,
        input  out_rs1_ready, out_rs2_ready, free_count
    );

    modport slave (
        input  ren_valid, ren_reg_write, ren_rd, ren_rs1, ren_rs2,
        input  wb_valid, wb_prd,
        input  commit_valid, commit_reg_write, commit_rd, commit_prd, commit_old_prd,
        input  flush,
        output ren_ready, out_valid, out_prd, out_old_prd, out_prs1, out_prs2,
        output out_rs1_ready, out_rs2_ready, free_count
    );

endinterface

// File: rtl/free_list_ring.sv
// -----------------------------------------------------------------------------
// free_list_ring
// Circular free list of physical tags with a speculative head, a tail and a
// retire head. The retire head marks where head would be if every uncommitted
// rename were discarded, so recovery is a single pointer copy.
//   clk, rst        : clock, synchronous active-high reset
//   pop_i           : consume the tag at head
//   push_i          : append push_tag_i at tail
//   push_tag_i      : tag being released
//   commit_adv_i    : advance the retire head by one
//   recover_i       : head <= retire head, count <= FL_DEPTH
//   head_tag_o      : tag at head (next allocation)
//   count_o         : registered number of free entries
// -----------------------------------------------------------------------------
module free_list_ring
    import rename_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    pop_i,
    input  logic    push_i,
    input  preg_t   push_tag_i,
    input  logic    commit_adv_i,
    input  logic    recover_i,
    output preg_t   head_tag_o,
    output fl_cnt_t count_o
);

    preg_t   fl_q [FL_DEPTH];
    preg_t   fl_d [FL_DEPTH];
    fl_idx_t head_q, head_d;
    fl_idx_t tail_q, tail_d;
    fl_idx_t rhead_q, rhead_d;
    fl_cnt_t count_q, count_d;

    always_comb begin
        fl_d    = fl_q;
        head_d  = head_q;
        tail_d  = tail_q;
        rhead_d = rhead_q;
        count_d = count_q;

        if (pop_i) begin
            head_d = fl_inc(head_q);
        end
        if (push_i) begin
            fl_d[tail_q] = push_tag_i;
            tail_d       = fl_inc(tail_q);
        end
        if (commit_adv_i) begin
            rhead_d = fl_inc(rhead_q);
        end

        unique case ({pop_i, push_i})
            2'b10:   count_d = count_q - fl_cnt_t'(1);
            2'b01:   count_d = count_q + fl_cnt_t'(1);
            default: count_d = count_q;
        endcase

        // Recovery uses the retire head including this cycle's commit, and
        // every entry between retire head and tail becomes free again.
        if (recover_i) begin
            head_d  = rhead_d;
            count_d = fl_cnt_t'(FL_DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < FL_DEPTH; k++) begin
                fl_q[k] <= preg_t'(NUM_AREG + k);
            end
            head_q  <= '0;
            tail_q  <= '0;
            rhead_q <= '0;
            count_q <= fl_cnt_t'(FL_DEPTH);
        end else begin
            fl_q    <= fl_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            rhead_q <= rhead_d;
            count_q <= count_d;
        end
    end

    assign head_tag_o = fl_q[head_q];
    assign count_o    = count_q;

endmodule

// File: rtl/rename_map.sv
// -----------------------------------------------------------------------------
// rename_map
// Single-wide register rename stage between decode and dispatch. Keeps a
// speculative RAT, a retirement RAT and per-physical-register busy bits, and
// draws destination tags from free_list_ring. A flush restores RAT from RRAT
// and rewinds the free list in one cycle.
//   clk, rst : clock, synchronous active-high reset
//   rn       : rename_map_if slave (decode request, registered result,
//              writeback, commit, flush, free_count)
// -----------------------------------------------------------------------------
module rename_map
    import rename_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    rename_map_if.slave  rn
);

    preg_t             rat_q  [NUM_AREG];
    preg_t             rat_d  [NUM_AREG];
    preg_t             rrat_q [NUM_AREG];
    preg_t             rrat_d [NUM_AREG];
    logic [NUM_PREG-1:0] busy_q, busy_d;
    rename_out_t       out_q, out_d;

    preg_t   fl_head_tag;
    fl_cnt_t free_count;
    logic    ren_ready;
    logic    accept;
    logic    alloc;
    logic    commit_we;

    // Ready when not busy, or when the producer writes back this very cycle.
    // x0 is permanently p0 and always ready.
    function automatic logic src_ready(input areg_t rs, input preg_t tag,
                                       input logic [NUM_PREG-1:0] busy,
                                       input logic wb_v, input preg_t wb_tag);
        if (rs == '0) begin
            return 1'b1;
        end
        return !busy[tag] || (wb_v && (wb_tag == tag));
    endfunction

    assign ren_ready = !rn.flush && (free_count != '0);
    assign accept    = rn.ren_valid && ren_ready;
    assign alloc     = accept && rn.ren_reg_write && (rn.ren_rd != '0);
    assign commit_we = rn.commit_valid && rn.commit_reg_write && (rn.commit_rd != '0);

    free_list_ring u_free_list (
        .clk          (clk),
        .rst          (rst),
        .pop_i        (alloc),
        .push_i       (commit_we),
        .push_tag_i   (rn.commit_old_prd),
        .commit_adv_i (commit_we),
        .recover_i    (rn.flush),
        .head_tag_o   (fl_head_tag),
        .count_o      (free_count)
    );

    // Result register: sources read the RAT before this cycle's update, so
    // rs == rd returns the previous mapping.
    always_comb begin
        out_d = '0;
        if (accept) begin
            out_d.valid     = 1'b1;
            out_d.prs1      = (rn.ren_rs1 == '0) ? '0 : rat_q[rn.ren_rs1];
            out_d.prs2      = (rn.ren_rs2 == '0) ? '0 : rat_q[rn.ren_rs2];
            out_d.rs1_ready = src_ready(rn.ren_rs1, rat_q[rn.ren_rs1], busy_q,
                                        rn.wb_valid, rn.wb_prd);
            out_d.rs2_ready = src_ready(rn.ren_rs2, rat_q[rn.ren_rs2], busy_q,
                                        rn.wb_valid, rn.wb_prd);
            if (alloc) begin
                out_d.prd     = fl_head_tag;
                out_d.old_prd = rat_q[rn.ren_rd];
            end
        end
    end

    always_comb begin
        rat_d  = rat_q;
        rrat_d = rrat_q;
        busy_d = busy_q;

        if (rn.wb_valid) begin
            busy_d[rn.wb_prd] = 1'b0;
        end
        // Allocation is applied after writeback so it wins on a tag clash.
        if (alloc) begin
            rat_d[rn.ren_rd]   = fl_head_tag;
            busy_d[fl_head_tag] = 1'b1;
        end
        if (commit_we) begin
            rrat_d[rn.commit_rd] = rn.commit_prd;
        end
        // Recovery copies the RRAT including this cycle's commit.
        if (rn.flush) begin
            rat_d  = rrat_d;
            busy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_AREG; i++) begin
                rat_q[i]  <= preg_t'(i);
                rrat_q[i] <= preg_t'(i);
            end
            busy_q <= '0;
            out_q  <= '0;
        end else begin
            rat_q  <= rat_d;
            rrat_q <= rrat_d;
            busy_q <= busy_d;
            out_q  <= out_d;
        end
    end

    assign rn.ren_ready     = ren_ready;
    assign rn.out_valid     = out_q.valid;
    assign rn.out_prd       = out_q.prd;
    assign rn.out_old_prd   = out_q.old_prd;
    assign rn.out_prs1      = out_q.prs1;
    assign rn.out_prs2      = out_q.prs2;
    assign rn.out_rs1_ready = out_q.rs1_ready;
    assign rn.out_rs2_ready = out_q.rs2_ready;
    assign rn.free_count    = free_count;

    // Releasing a tag into an already full free list means the ROB freed a
    // register it never allocated.
    a_commit_overflow: assert property (@(posedge clk) disable iff (rst)
        !(commit_we && (free_count == fl_cnt_t'(FL_DEPTH))));

endmodule

// File: tb/tb_rename_map.sv
module tb_rename_map;
    import rename_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rename_map_if rif ();

    rename_map dut (
        .clk (clk),
        .rst (rst),
        .rn  (rif)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        rif.ren_valid        = 1'b0;
        rif.ren_reg_write    = 1'b0;
        rif.ren_rd           = '0;
        rif.ren_rs1          = '0;
        rif.ren_rs2          = '0;
        rif.wb_valid         = 1'b0;
        rif.wb_prd           = '0;
        rif.commit_valid     = 1'b0;
        rif.commit_reg_write = 1'b0;
        rif.commit_rd        = '0;
        rif.commit_prd       = '0;
        rif.commit_old_prd   = '0;
        rif.flush            = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One rename request for one cycle; other inputs are left as the caller set them.
    task automatic ren(input int rd, input int rs1, input int rs2, input logic we);
        rif.ren_valid     = 1'b1;
        rif.ren_reg_write = we;
        rif.ren_rd        = areg_t'(rd);
        rif.ren_rs1       = areg_t'(rs1);
        rif.ren_rs2       = areg_t'(rs2);
        tick();
        rif.ren_valid     = 1'b0;
        rif.ren_reg_write = 1'b0;
    endtask

    task automatic set_commit(input int rd, input int prd, input int old_prd);
        rif.commit_valid     = 1'b1;
        rif.commit_reg_write = 1'b1;
        rif.commit_rd        = areg_t'(rd);
        rif.commit_prd       = preg_t'(prd);
        rif.commit_old_prd   = preg_t'(old_prd);
    endtask

    task automatic clr_commit();
        rif.commit_valid     = 1'b0;
        rif.commit_reg_write = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rif.free_count !== 6'd32) begin errors++; $display("FAIL reset_free_count got %0d want 32", rif.free_count); end
        checks++; if (rif.ren_ready !== 1'b1) begin errors++; $display("FAIL reset_ren_ready got %b want 1", rif.ren_ready); end
        checks++; if (rif.out_valid !== 1'b0 || rif.out_prd !== '0 || rif.out_prs1 !== '0) begin errors++;
            $display("FAIL reset_outputs got v=%b prd=%0d prs1=%0d want 0/0/0", rif.out_valid, rif.out_prd, rif.out_prs1); end
        // rs == rd reads the mapping before the update
        ren(2, 2, 0, 1'b1);
        checks++; if (rif.out_prd !== 6'd32 || rif.out_old_prd !== 6'd2 || rif.out_prs1 !== 6'd2) begin errors++;
            $display("FAIL rs_eq_rd got prd=%0d old=%0d prs1=%0d want 32/2/2", rif.out_prd, rif.out_old_prd, rif.out_prs1); end
        // reset asserted alongside a rename request wins
        rst = 1'b1;
        rif.ren_valid = 1'b1; rif.ren_reg_write = 1'b1; rif.ren_rd = areg_t'(4);
        tick();
        drive_idle();
        rst = 1'b0;
        checks++; if (rif.out_valid !== 1'b0 || rif.free_count !== 6'd32) begin errors++;
            $display("FAIL midrun_reset got v=%b fc=%0d want 0/32", rif.out_valid, rif.free_count); end
        ren(2, 0, 0, 1'b1);
        checks++; if (rif.out_prd !== 6'd32 || rif.out_old_prd !== 6'd2) begin errors++;
            $display("FAIL after_reset_alloc got prd=%0d old=%0d want 32/2", rif.out_prd, rif.out_old_prd); end
    endtask

    task automatic test_basic();
        do_reset();
        ren(3, 1, 2, 1'b1);
        checks++; if (rif.out_valid !== 1'b1 || rif.out_prd !== 6'd32 || rif.out_old_prd !== 6'd3) begin errors++;
            $display("FAIL add1_dest got v=%b prd=%0d old=%0d want 1/32/3", rif.out_valid, rif.out_prd, rif.out_old_prd); end
        checks++; if (rif.out_prs1 !== 6'd1 || rif.out_prs2 !== 6'd2 || rif.out_rs1_ready !== 1'b1 || rif.out_rs2_ready !== 1'b1) begin errors++;
            $display("FAIL add1_src got prs1=%0d prs2=%0d r1=%b r2=%b want 1/2/1/1", rif.out_prs1, rif.out_prs2, rif.out_rs1_ready, rif.out_rs2_ready); end
        ren(4, 3, 3, 1'b1);
        checks++; if (rif.out_prd !== 6'd33 || rif.out_old_prd !== 6'd4 || rif.out_prs1 !== 6'd32 || rif.out_prs2 !== 6'd32) begin errors++;
            $display("FAIL add2_tags got prd=%0d old=%0d prs1=%0d prs2=%0d want 33/4/32/32", rif.out_prd, rif.out_old_prd, rif.out_prs1, rif.out_prs2); end
        checks++; if (rif.out_rs1_ready !== 1'b0 || rif.out_rs2_ready !== 1'b0 || rif.free_count !== 6'd30) begin errors++;
            $display("FAIL add2_ready got r1=%b r2=%b fc=%0d want 0/0/30", rif.out_rs1_ready, rif.out_rs2_ready, rif.free_count); end
        tick();
        checks++; if (rif.out_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse got %b want 0", rif.out_valid); end
    endtask

    task automatic test_full_and_refill();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            ren(((2 + i) % 31) + 1, 0, 0, 1'b1);
        end
        checks++; if (rif.out_prd !== 6'd63 || rif.out_old_prd !== 6'd32) begin errors++;
            $display("FAIL last_alloc got prd=%0d old=%0d want 63/32", rif.out_prd, rif.out_old_prd); end
        checks++; if (rif.free_count !== 6'd0 || rif.ren_ready !== 1'b0) begin errors++;
            $display("FAIL empty got fc=%0d rdy=%b want 0/0", rif.free_count, rif.ren_ready); end
        ren(5, 0, 0, 1'b1);
        checks++; if (rif.out_valid !== 1'b0 || rif.free_count !== 6'd0) begin errors++;
            $display("FAIL empty_reject got v=%b fc=%0d want 0/0", rif.out_valid, rif.free_count); end
        set_commit(3, 32, 3);
        tick();
        clr_commit();
        checks++; if (rif.free_count !== 6'd1 || rif.ren_ready !== 1'b1) begin errors++;
            $display("FAIL refill got fc=%0d rdy=%b want 1/1", rif.free_count, rif.ren_ready); end
        ren(7, 3, 0, 1'b1);
        checks++; if (rif.out_prd !== 6'd3 || rif.out_old_prd !== 6'd36 || rif.out_prs1 !== 6'd63 || rif.out_rs1_ready !== 1'b0) begin errors++;
            $display("FAIL reuse_p3 got prd=%0d old=%0d prs1=%0d r1=%b want 3/36/63/0", rif.out_prd, rif.out_old_prd, rif.out_prs1, rif.out_rs1_ready); end
        checks++; if (rif.free_count !== 6'd0 || rif.out_rs2_ready !== 1'b1 || rif.out_prs2 !== 6'd0) begin errors++;
            $display("FAIL reuse_misc got fc=%0d r2=%b prs2=%0d want 0/1/0", rif.free_count, rif.out_rs2_ready, rif.out_prs2); end
    endtask

    task automatic test_alloc_commit();
        do_reset();
        for (int i = 0; i < 27; i++) begin
            ren(i + 1, 0, 0, 1'b1);
        end
        checks++; if (rif.free_count !== 6'd5) begin errors++; $display("FAIL fc_before got %0d want 5", rif.free_count); end
        set_commit(1, 32, 1);
        ren(10, 0, 0, 1'b1);
        clr_commit();
        checks++; if (rif.free_count !== 6'd5 || rif.out_prd !== 6'd59 || rif.out_old_prd !== 6'd41) begin errors++;
            $display("FAIL same_cycle got fc=%0d prd=%0d old=%0d want 5/59/41", rif.free_count, rif.out_prd, rif.out_old_prd); end
        ren(0, 1, 10, 1'b0);
        checks++; if (rif.out_prs1 !== 6'd32 || rif.out_prs2 !== 6'd59 || rif.out_prd !== 6'd0 || rif.free_count !== 6'd5) begin errors++;
            $display("FAIL rat_view got prs1=%0d prs2=%0d prd=%0d fc=%0d want 32/59/0/5", rif.out_prs1, rif.out_prs2, rif.out_prd, rif.free_count); end
        rif.flush = 1'b1;
        tick();
        rif.flush = 1'b0;
        ren(0, 1, 10, 1'b0);
        checks++; if (rif.out_prs1 !== 6'd32 || rif.out_prs2 !== 6'd10 || rif.out_rs1_ready !== 1'b1 || rif.out_rs2_ready !== 1'b1) begin errors++;
            $display("FAIL rrat_view got prs1=%0d prs2=%0d r1=%b r2=%b want 32/10/1/1", rif.out_prs1, rif.out_prs2, rif.out_rs1_ready, rif.out_rs2_ready); end
    endtask

    task automatic test_flush();
        do_reset();
        ren(3, 0, 0, 1'b1);
        ren(4, 0, 0, 1'b1);
        ren(5, 0, 0, 1'b1);
        ren(6, 0, 0, 1'b1);
        set_commit(3, 32, 3);
        tick();
        clr_commit();
        checks++; if (rif.free_count !== 6'd29) begin errors++; $display("FAIL pre_flush_fc got %0d want 29", rif.free_count); end
        rif.flush = 1'b1;
        rif.ren_valid = 1'b1; rif.ren_reg_write = 1'b1; rif.ren_rd = areg_t'(9);
        #1;
        checks++; if (rif.ren_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", rif.ren_ready); end
        tick();
        drive_idle();
        checks++; if (rif.free_count !== 6'd32 || rif.out_valid !== 1'b0) begin errors++;
            $display("FAIL flush_state got fc=%0d v=%b want 32/0", rif.free_count, rif.out_valid); end
        ren(8, 3, 4, 1'b1);
        checks++; if (rif.out_prd !== 6'd33 || rif.out_old_prd !== 6'd8 || rif.free_count !== 6'd31) begin errors++;
            $display("FAIL post_flush_alloc got prd=%0d old=%0d fc=%0d want 33/8/31", rif.out_prd, rif.out_old_prd, rif.free_count); end
        checks++; if (rif.out_prs1 !== 6'd32 || rif.out_prs2 !== 6'd4 || rif.out_rs1_ready !== 1'b1 || rif.out_rs2_ready !== 1'b1) begin errors++;
            $display("FAIL post_flush_src got prs1=%0d prs2=%0d r1=%b r2=%b want 32/4/1/1", rif.out_prs1, rif.out_prs2, rif.out_rs1_ready, rif.out_rs2_ready); end
    endtask

    task automatic test_bypass_and_x0();
        do_reset();
        ren(3, 0, 0, 1'b1);
        rif.wb_valid = 1'b1;
        rif.wb_prd   = preg_t'(32);
        ren(5, 3, 3, 1'b1);
        rif.wb_valid = 1'b0;
        checks++; if (rif.out_prs1 !== 6'd32 || rif.out_rs1_ready !== 1'b1 || rif.out_rs2_ready !== 1'b1 || rif.out_prd !== 6'd33) begin errors++;
            $display("FAIL bypass got prs1=%0d r1=%b r2=%b prd=%0d want 32/1/1/33", rif.out_prs1, rif.out_rs1_ready, rif.out_rs2_ready, rif.out_prd); end
        ren(0, 0, 5, 1'b1);
        checks++; if (rif.out_valid !== 1'b1 || rif.out_prd !== 6'd0 || rif.out_old_prd !== 6'd0 || rif.free_count !== 6'd30) begin errors++;
            $display("FAIL rd0 got v=%b prd=%0d old=%0d fc=%0d want 1/0/0/30", rif.out_valid, rif.out_prd, rif.out_old_prd, rif.free_count); end
        checks++; if (rif.out_prs1 !== 6'd0 || rif.out_rs1_ready !== 1'b1 || rif.out_prs2 !== 6'd33 || rif.out_rs2_ready !== 1'b0) begin errors++;
            $display("FAIL rd0_src got prs1=%0d r1=%b prs2=%0d r2=%b want 0/1/33/0", rif.out_prs1, rif.out_rs1_ready, rif.out_prs2, rif.out_rs2_ready); end
        ren(0, 3, 0, 1'b0);
        checks++; if (rif.out_prs1 !== 6'd32 || rif.out_rs1_ready !== 1'b1) begin errors++;
            $display("FAIL wb_cleared got prs1=%0d r1=%b want 32/1", rif.out_prs1, rif.out_rs1_ready); end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_basic();
        test_full_and_refill();
        test_alloc_commit();
        test_flush();
        test_bypass_and_x0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
